// File: rtl/bram_sdp.sv
// Simple-dual-port behavioural block RAM: byte-enabled write port, RD_LAT-stage read pipeline,
// sticky out-of-range flag. Define BRAM_SDP_BYPASS_EN for write-first same-word collisions.
module bram_sdp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wen_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   wa_i,
  input  logic [DATA_W-1:0]   di_i,
  input  logic                ren_i,
  input  logic [ADDR_W-1:0]   ra_i,
  output logic [DATA_W-1:0]   do_o,
  output logic                rval_o,
  output logic                err_o
);
  localparam int NB      = DATA_W / 8;
  localparam int BYTE_SH = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [IDX_W-1:0]  wr_word, rd_word;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pipe_q [RD_LAT];
  logic [RD_LAT-1:0] pipe_v_q;
  logic              err_d, err_q;

  assign wr_idx  = wa_i >> BYTE_SH;
  assign rd_idx  = ra_i >> BYTE_SH;
  assign wr_ok   = wr_idx < ADDR_W'(DEPTH);
  assign rd_ok   = rd_idx < ADDR_W'(DEPTH);
  assign wr_word = wr_idx[IDX_W-1:0];
  assign rd_word = rd_idx[IDX_W-1:0];

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = mem_q[rd_word];
`ifdef BRAM_SDP_BYPASS_EN
      // Write-first: strobed bytes of a same-word write are forwarded into the read.
      if (wen_i && wr_ok && (wr_word == rd_word)) begin
        for (int b = 0; b < NB; b++) begin
          if (we_i[b]) rd_data[8*b +: 8] = di_i[8*b +: 8];
        end
      end
`endif
    end
  end

  // NOTE: the storage array is deliberately not reset, so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wen_i && wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) mem_q[wr_word][8*b +: 8] <= di_i[8*b +: 8];
      end
    end
  end

  // Each stage only loads when its predecessor is valid, so do_o holds between completions.
  // NOTE: sequential state uses non-blocking assignments so stages shift, not fall through.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v_q <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_q[s] <= '0;
    end else begin
      pipe_v_q[0] <= ren_i;
      if (ren_i) pipe_q[0] <= rd_data;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v_q[s] <= pipe_v_q[s-1];
        if (pipe_v_q[s-1]) pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign err_d = err_q | (wen_i & ~wr_ok) | (ren_i & ~rd_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign do_o   = pipe_q[RD_LAT-1];
  assign rval_o = pipe_v_q[RD_LAT-1];
  assign err_o  = err_q;

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: three instances (RD_LAT 1/3/4) on shared inputs, checked every cycle
// against a history-based reference model, plus directed scenarios and randomized traffic.
module tb_bram_sdp;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wen_i = 1'b0;
  logic [3:0]  we_i = '0;
  logic [11:0] wa_i = '0;
  logic [31:0] di_i = '0;
  logic        ren_i = 1'b0;
  logic [11:0] ra_i = '0;

  logic [31:0] do_l1, do_l3, do_l4;
  logic        rval_l1, rval_l3, rval_l4;
  logic        err_l1, err_l3, err_l4;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  bram_sdp #(.DATA_W(32), .DEPTH(12), .ADDR_W(12), .RD_LAT(1)) u_l1 (
    .clk_i(clk), .rst_i(rst_i), .wen_i(wen_i), .we_i(we_i), .wa_i(wa_i), .di_i(di_i),
    .ren_i(ren_i), .ra_i(ra_i), .do_o(do_l1), .rval_o(rval_l1), .err_o(err_l1));
  bram_sdp #(.DATA_W(32), .DEPTH(12), .ADDR_W(12), .RD_LAT(3)) u_l3 (
    .clk_i(clk), .rst_i(rst_i), .wen_i(wen_i), .we_i(we_i), .wa_i(wa_i), .di_i(di_i),
    .ren_i(ren_i), .ra_i(ra_i), .do_o(do_l3), .rval_o(rval_l3), .err_o(err_l3));
  bram_sdp #(.DATA_W(32), .DEPTH(12), .ADDR_W(12), .RD_LAT(4)) u_l4 (
    .clk_i(clk), .rst_i(rst_i), .wen_i(wen_i), .we_i(we_i), .wa_i(wa_i), .di_i(di_i),
    .ren_i(ren_i), .ra_i(ra_i), .do_o(do_l4), .rval_o(rval_l4), .err_o(err_l4));

  // Reference model: word array, per-edge record of issued reads, and the last reset edge.
  // Expected output for latency L after edge n is the read issued at edge n-L+1, if any
  // and if no reset came since; otherwise Do holds.
  logic [31:0] mem_m [12];
  logic        hist_v [2048];
  logic [31:0] hist_d [2048];
  int          edge_n = 0;
  int          last_rst = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_do [3];
  logic        exp_rv [3];
  int          lats [3] = '{1, 3, 4};

  always @(posedge clk) begin
    int widx, ridx, src;
    logic [31:0] rdv;
    edge_n++;
    if (rst_i) begin
      last_rst = edge_n;
      exp_err = 1'b0;
      hist_v[edge_n] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_do[k] = '0;
        exp_rv[k] = 1'b0;
      end
    end else begin
      widx = int'(wa_i) / 4;
      ridx = int'(ra_i) / 4;
      rdv = '0;
      if (ren_i && ridx < 12) rdv = mem_m[ridx];
      if ((ren_i && ridx >= 12) || (wen_i && widx >= 12)) exp_err = 1'b1;
      if (wen_i && widx < 12) begin
        for (int b = 0; b < 4; b++) begin
          if (we_i[b]) mem_m[widx][8*b +: 8] = di_i[8*b +: 8];
        end
      end
`ifdef BRAM_SDP_BYPASS_EN
      if (ren_i && ridx < 12) rdv = mem_m[ridx];
`endif
      hist_v[edge_n] = ren_i;
      hist_d[edge_n] = rdv;
      for (int k = 0; k < 3; k++) begin
        src = edge_n - lats[k] + 1;
        if (src > last_rst && hist_v[src]) begin
          exp_rv[k] = 1'b1;
          exp_do[k] = hist_d[src];
        end else begin
          exp_rv[k] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("do_l1",   do_l1,   exp_do[0]);
    check("rval_l1", 32'(rval_l1), 32'(exp_rv[0]));
    check("do_l3",   do_l3,   exp_do[1]);
    check("rval_l3", 32'(rval_l3), 32'(exp_rv[1]));
    check("do_l4",   do_l4,   exp_do[2]);
    check("rval_l4", 32'(rval_l4), 32'(exp_rv[2]));
    check("err_l1",  32'(err_l1), 32'(exp_err));
    check("err_l3",  32'(err_l3), 32'(exp_err));
    check("err_l4",  32'(err_l4), 32'(exp_err));
  endtask

  // Inputs change on the falling edge; outputs are compared on the following falling edge.
  task automatic drive(input logic wen, input logic [3:0] we, input logic [11:0] wa,
                       input logic [31:0] di, input logic ren, input logic [11:0] ra);
    wen_i = wen; we_i = we; wa_i = wa; di_i = di; ren_i = ren; ra_i = ra;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got_n, first_c, last_c;
    logic [31:0] got [12];
    logic [31:0] coll_exp;

    // Reset state.
    idle();
    idle();
    check("rst_do",   do_l1, 32'h0);
    check("rst_rval", 32'(rval_l1), 32'h0);
    check("rst_err",  32'(err_l1), 32'h0);
    rst_i = 1'b0;

    // Preload word i with value i.
    for (int i = 0; i < 12; i++) drive(1'b1, 4'hF, 12'(i * 4), 32'(i), 1'b0, 12'h0);

    // Basic write/read at RD_LAT=1.
    drive(1'b1, 4'hF, 12'h008, 32'h11223344, 1'b0, 12'h0);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h008);
    check("basic_rval", 32'(rval_l1), 32'h1);
    check("basic_do",   do_l1, 32'h11223344);
    check("basic_err",  32'(err_l1), 32'h0);
    idle();
    check("basic_pulse", 32'(rval_l1), 32'h0);

    // Byte strobes over a zero word.
    drive(1'b1, 4'hF, 12'h004, 32'h0, 1'b0, 12'h0);
    drive(1'b1, 4'b0101, 12'h004, 32'hAABBCCDD, 1'b0, 12'h0);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h004);
    check("strobe_do", do_l1, 32'h00BB00DD);

    // Restore index values, then back-to-back reads at RD_LAT=3.
    drive(1'b1, 4'hF, 12'h004, 32'd1, 1'b0, 12'h0);
    drive(1'b1, 4'hF, 12'h008, 32'd2, 1'b0, 12'h0);
    idle();
    idle();
    idle();
    got_n = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 15; i++) begin
      if (i < 12) drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'(i * 4));
      else        idle();
      if (rval_l3) begin
        if (got_n < 12) got[got_n] = do_l3;
        if (first_c < 0) first_c = i;
        last_c = i;
        got_n++;
      end
    end
    check("pipe_count", 32'(got_n), 32'd12);
    check("pipe_first", 32'(first_c), 32'd2);
    check("pipe_span",  32'(last_c - first_c), 32'd11);
    for (int i = 0; i < 12; i++) check($sformatf("pipe_do%0d", i), got[i], 32'(i));

    // Same-word collision.
    drive(1'b1, 4'hF, 12'h008, 32'h0, 1'b0, 12'h0);
`ifdef BRAM_SDP_BYPASS_EN
    coll_exp = 32'h0000FFFF;
`else
    coll_exp = 32'h00000000;
`endif
    drive(1'b1, 4'b0011, 12'h008, 32'hFFFFFFFF, 1'b1, 12'h008);
    check("coll_do", do_l1, coll_exp);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h008);
    check("coll_follow", do_l1, 32'h0000FFFF);

    // Out-of-range write then read.
    check("oor_err_before", 32'(err_l1), 32'h0);
    drive(1'b1, 4'hF, 12'h030, 32'hDEADBEEF, 1'b0, 12'h0);
    check("oor_err_wr", 32'(err_l1), 32'h1);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h030);
    check("oor_rd_rval", 32'(rval_l1), 32'h1);
    check("oor_rd_do",   do_l1, 32'h0);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h02C);
    check("oor_mem_kept", do_l1, 32'd11);
    idle();
    check("oor_sticky", 32'(err_l1), 32'h1);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom), 12'($urandom_range(0, 51)),
            $urandom, 1'($urandom_range(0, 2) != 0), 12'($urandom_range(0, 51)));
    end
    rst_i = 1'b0;
    idle();

    // Reset with reads in flight at RD_LAT=4.
    drive(1'b1, 4'hF, 12'h040, 32'h1, 1'b0, 12'h0);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h004);
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h008);
    rst_i = 1'b1;
    idle();
    check("mid_rst_err", 32'(err_l4), 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      check($sformatf("mid_rst_rval%0d", i), 32'(rval_l4), 32'h0);
    end
    check("mid_rst_do",  do_l4, 32'h0);
    check("mid_rst_err2", 32'(err_l4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/bram_sdp.md
# bram_sdp

Parametrised simple-dual-port behavioural block RAM, the successor to the fixed 12-word single-port BRAM used for tap and data storage in the FIR datapath. It has one byte-enabled write port and one independent read port with configurable read latency. A valid strobe accompanies read data, and a sticky error flag records out-of-range accesses. It sits between the AXI-Lite/AXI-Stream front ends and the FIR engine. It is simulation-only behavioural code, like its predecessor.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- DEPTH, 12, number of words
- ADDR_W, 12, byte-address width
- RD_LAT, 1, read latency in cycles; legal 1..4
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- WEN  in  1  write-port enable
- WE  in  DATA_W/8  byte write strobes; bit i covers Di[8i+7:8i]
- WA  in  ADDR_W  write byte address; word index = WA >> log2(DATA_W/8)
- Di  in  DATA_W  write data
- REN  in  1  read request
- RA  in  ADDR_W  read byte address; same word mapping as WA
- Do  out  DATA_W  read data
- RVAL  out  1  read data valid, one-cycle pulse per request
- ERR  out  1  sticky out-of-range flag

## Operation
- Write: at an edge with WEN=1 and word index < DEPTH, every byte with WE[i]=1 is updated. If WE is all zeros, nothing changes.
- Read issue: at an edge with REN=1, the word at RA is sampled into stage 1 of the read pipeline. Stages 2..RD_LAT are pure delay. Later writes do not alter data already issued.
- Do and RVAL are driven from the last pipeline stage. Do holds its last value when no read completes; it is not gated to zero.
- Back-to-back reads are accepted every cycle. There is no stall or backpressure; throughput is 1 word per cycle.
- Out-of-range write (word index ≥ DEPTH): the write is dropped, memory is unchanged, and ERR is set.
- Out-of-range read: the request still produces RVAL after RD_LAT cycles, with Do = 0. ERR is set.
- ERR stays at 1 until RST; only RST clears it.
- Same-word collision (WEN and REN at the same edge, same word index): the result is set by the configuration macro, below.
- Memory contents are not reset and start as X in simulation.

## Timing
- Reset values: Do = 0, RVAL = 0, ERR = 0, all pipeline valid bits = 0.
- RST=1 mid-operation:
  - In-flight reads are discarded; no RVAL is produced for them.
  - Writes and REN at the same edge are ignored.
- Latency: a request issued at edge t produces Do/RVAL valid from edge t+RD_LAT−1 through the next edge. With RD_LAT=1, data appears in the cycle after the issue edge, matching the predecessor's registered-address read.
- RVAL count equals accepted REN count, in order; there is no reordering.
- ERR rises one cycle after the offending edge.

## Configuration
- BRAM_SDP_BYPASS_EN defined: on a same-word collision, the read returns write-first data, merged per byte. Bytes with WE[i]=1 return Di, and the other bytes return the old contents.
- BRAM_SDP_BYPASS_EN undefined: on a same-word collision, the read returns read-first data, i.e. the full old word.
- In both cases the memory holds the new data after the edge.

## Test plan
- Reset, then write 0x11223344 to WA=0x8 with WE=4'hF, then read RA=0x8 with RD_LAT=1. Required: RVAL pulses 1 cycle after the issue edge with Do=0x11223344; ERR=0.
- Byte strobes:
  - Write 0xAABBCCDD to word 1 with WE=4'b0101 over prior contents 0x00000000.
  - Required: the read returns 0x00BB00DD.
- Pipelined reads, RD_LAT=3, DEPTH=12:
  - Issue REN every cycle for words 0..11, preloaded with value = index.
  - Required: 12 consecutive RVAL pulses starting 3 cycles after the first issue, Do = 0..11 in order.
- Collision: word 2 holds 0x0; at one edge write 0xFFFFFFFF with WE=4'b0011 and read word 2.
  - With the macro defined: Do = 0x0000FFFF.
  - With the macro undefined: Do = 0x00000000.
  - In both builds, a follow-up read returns 0x0000FFFF.
- Out-of-range: write WA=0x30 (word 12, DEPTH=12), then read RA=0x30.
  - Required: memory is unchanged and ERR=1 from the next cycle.
  - The read yields RVAL with Do=0, and ERR stays 1 until RST.
- Reset mid-flight, RD_LAT=4: issue 2 reads, then assert RST 2 cycles later. Required: no RVAL for either read, and Do=0, ERR=0 after reset.
